// File: rtl/cmp_arb_pkg.sv
// Shared constants and state encoding for the comparator-sharing arbiter.
package cmp_arb_pkg;

  localparam int unsigned CMP_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StIssue = ST_ISSUE,
    StResp  = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/cmp_share_arb_if.sv
// Bus bundle between requesters, the arbiter and the shared comparator.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface cmp_share_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  import cmp_arb_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [CMP_W*N_REQ-1:0] req_a;
  logic [CMP_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [CMP_W-1:0]       cmp_a;
  logic [CMP_W-1:0]       cmp_b;
  logic                   cmp_o;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_o;
  logic                   busy;
  logic                   err;

  modport slave (
    input  req_valid, req_a, req_b, cmp_o, rsp_ready,
    output req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_o, busy, err
  );

  modport master (
    output req_valid, req_a, req_b, cmp_o, rsp_ready,
    input  req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_o, busy, err
  );
endinterface

// File: rtl/cmp_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module cmp_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = |req;
    for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
      j = (int'(ptr) + off) % int'(N_REQ);
      if (req[j]) idx = ID_W'(j);
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one 2-bit inequality comparator among N_REQ requesters.
// Optional self-check of the comparator result is enabled by defining CMP_ARB_CHECK_EN.
module cmp_share_arb
  import cmp_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic           clk,
  input logic           rst,
  cmp_share_arb_if.slave bus
);

  if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
    $error("cmp_share_arb: ID_W must equal clog2(N_REQ)");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("cmp_share_arb: N_REQ must be in 2..16");
  end

  arb_state_e       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [CMP_W-1:0] cmp_a_q, cmp_b_q;
  logic             rsp_valid_q, rsp_o_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             err_q;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [CMP_W-1:0] sel_a, sel_b;

  cmp_rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req(bus.req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(gnt_any)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = bus.req_a[CMP_W*32'(gnt_idx) +: CMP_W];
    sel_b = bus.req_b[CMP_W*32'(gnt_idx) +: CMP_W];
  end

  // Transaction FSM with all response-side outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_o_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            cmp_a_q  <= sel_a;
            cmp_b_q  <= sel_b;
            rsp_id_q <= gnt_idx;
            ptr_q    <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          rsp_o_q     <= bus.cmp_o;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
`ifdef CMP_ARB_CHECK_EN
          if (bus.cmp_o != (cmp_a_q != cmp_b_q)) err_q <= 1'b1;
`endif
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grants are only offered while idle; the pulse is combinational.
  always_comb begin
    bus.req_ready = (state_q == StIdle) ? gnt : '0;
    bus.cmp_a     = cmp_a_q;
    bus.cmp_b     = cmp_b_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_id    = rsp_id_q;
    bus.rsp_o     = rsp_o_q;
    bus.busy      = (state_q != StIdle);
`ifdef CMP_ARB_CHECK_EN
    bus.err       = err_q;
`else
    bus.err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb with N_REQ=4 and an inequality comparator model.
module tb_cmp_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic invert = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

`ifdef CMP_ARB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  cmp_share_arb_if #(.N_REQ(4), .ID_W(2)) bus ();

  assign bus.cmp_o = invert ? (bus.cmp_a == bus.cmp_b) : (bus.cmp_a != bus.cmp_b);

  cmp_share_arb #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, " cmp_a"}, 32'(bus.cmp_a), 32'h0);
    check({tag, " cmp_b"}, 32'(bus.cmp_b), 32'h0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'h0);
    check({tag, " rsp_o"}, 32'(bus.rsp_o), 32'h0);
    check({tag, " busy"}, 32'(bus.busy), 32'h0);
    check({tag, " err"}, 32'(bus.err), 32'h0);
  endtask

  initial begin
    logic [1:0] exp_o [4];
    exp_o = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // 1: single request from 2, equal operands, response held until accepted.
    bus.req_valid = 4'b0100;
    bus.req_a     = 8'b00_11_00_00;
    bus.req_b     = 8'b00_11_00_00;
    #1;
    check("t1 ready pulse", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("t1 ready drop", 32'(bus.req_ready), 32'h0);
    check("t1 busy", 32'(bus.busy), 32'h1);
    check("t1 rsp_valid early", 32'(bus.rsp_valid), 32'h0);
    check("t1 cmp_a", 32'(bus.cmp_a), 32'h3);
    check("t1 cmp_b", 32'(bus.cmp_b), 32'h3);
    tick();
    check("t1 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1 rsp_id", 32'(bus.rsp_id), 32'h2);
    check("t1 rsp_o", 32'(bus.rsp_o), 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    check("t1 rsp_valid clr", 32'(bus.rsp_valid), 32'h0);
    check("t1 idle", 32'(bus.busy), 32'h0);

    // 2: single request from 0, unequal operands; pointer is 3 so search wraps to 0.
    bus.req_valid = 4'b0001;
    bus.req_a     = 8'b00_00_00_00;
    bus.req_b     = 8'b00_00_00_01;
    #1;
    check("t2 ready pulse", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    check("t2 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t2 rsp_id", 32'(bus.rsp_id), 32'h0);
    check("t2 rsp_o", 32'(bus.rsp_o), 32'h1);
    tick();
    check("t2 idle", 32'(bus.busy), 32'h0);

    // 5: reset during ISSUE of a grant to requester 1.
    bus.req_valid = 4'b0010;
    bus.req_a     = 8'b00_00_10_00;
    bus.req_b     = 8'b00_00_01_00;
    #1;
    check("t5 ready pulse", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("t5 in issue", 32'(bus.busy), 32'h1);
    check("t5 cmp_a latched", 32'(bus.cmp_a), 32'h2);
    rst = 1'b1;
    #1;
    check_reset_vals("t5 async rst");
    tick();
    rst = 1'b0;
    tick();
    check("t5 rsp stays clear", 32'(bus.rsp_valid), 32'h0);

    // 3: all four held valid; pointer reset means order 0,1,2,3,0 every 3 cycles.
    bus.req_valid = 4'b1111;
    bus.req_a     = 8'b11_10_01_00;
    bus.req_b     = 8'b11_01_01_00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3 grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      check("t3 ready issue", 32'(bus.req_ready), 32'h0);
      check("t3 cmp_a", 32'(bus.cmp_a), 32'(k % 4));
      tick();
      check("t3 rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("t3 rsp_id", 32'(bus.rsp_id), 32'(k % 4));
      check("t3 rsp_o", 32'(bus.rsp_o), 32'(exp_o[k % 4]));
      check("t3 ready resp", 32'(bus.req_ready), 32'h0);
      tick();
    end

    // 4: backpressure on requester 1's response.
    bus.rsp_ready = 1'b0;
    #1;
    check("t4 grant", 32'(bus.req_ready), 32'h2);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4 hold valid", 32'(bus.rsp_valid), 32'h1);
      check("t4 hold id", 32'(bus.rsp_id), 32'h1);
      check("t4 hold o", 32'(bus.rsp_o), 32'h0);
      check("t4 no grant", 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4 no grant on hs", 32'(bus.req_ready), 32'h0);
    tick();
    check("t4 released", 32'(bus.rsp_valid), 32'h0);
    check("t4 next grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("t4 next id", 32'(bus.rsp_id), 32'h2);
    tick();
    tick();

    // 6: faulty comparator; checker build flags err and keeps it until reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    invert        = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a     = 8'b00_00_00_01;
    bus.req_b     = 8'b00_00_00_01;
    tick();
    bus.req_valid = '0;
    check("t6 err before issue", 32'(bus.err), 32'h0);
    tick();
    check("t6 err", 32'(bus.err), 32'(EXP_ERR));
    check("t6 rsp_o passthru", 32'(bus.rsp_o), 32'h1);
    invert = 1'b0;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    check("t6 good rsp_o", 32'(bus.rsp_o), 32'h0);
    check("t6 err sticky", 32'(bus.err), 32'(EXP_ERR));
    tick();
    rst = 1'b1;
    #1;
    check("t6 err cleared", 32'(bus.err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
